// File: rtl/line_pkg.sv
// Shared types for the line-drawing front end: drawer-facing endpoint types,
// the packed segment-table entry and the sequencer state encoding.
package line_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;

  typedef struct packed {
    x_t x0;
    y_t y0;
    x_t x1;
    y_t y1;
  } segment_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/line_sequencer.sv
// Walks the segment table and hands each segment to the Bresenham drawer.
// Optional erase mode (colour 0 redraw, queueable from DONE): LINE_SEQ_ERASE_EN.
module line_sequencer
  import line_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              draw_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_segs,
`ifdef LINE_SEQ_ERASE_EN
  input  logic              erase,
`endif
  output logic [ADDR_W-1:0] seg_addr,
  input  logic [37:0]       seg_data,
  output x_t                x0,
  output y_t                y0,
  output x_t                x1,
  output y_t                y1,
  output logic              nextstate,
  input  logic              write_done,
  output logic              cleared,
  output logic              color,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_t        state_q, state_d;
  logic [ADDR_W:0]   index_q, index_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  segment_t          seg_q, seg_d;
  segment_t          seg_in;
  logic [ADDR_W:0]   last_idx;
`ifdef LINE_SEQ_ERASE_EN
  logic              color_q, color_d;
  logic              pend_q, pend_d;
  logic [ADDR_W:0]   pend_num_q, pend_num_d;
`endif

  assign seg_in   = segment_t'(seg_data);
  assign last_idx = num_q - {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
`ifdef LINE_SEQ_ERASE_EN
    color_d    = color_q;
    pend_d     = pend_q;
    pend_num_d = pend_num_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef LINE_SEQ_ERASE_EN
        // A queued erase frame wins over a fresh start in the same cycle.
        if (pend_q) begin
          pend_d  = 1'b0;
          num_d   = pend_num_q;
          index_d = '0;
          color_d = 1'b0;
          state_d = (pend_num_q == '0) ? S_DONE : S_FETCH;
        end else if (start) begin
          num_d   = num_segs;
          index_d = '0;
          color_d = ~erase;
          state_d = (num_segs == '0) ? S_DONE : S_FETCH;
        end
`else
        if (start) begin
          num_d   = num_segs;
          index_d = '0;
          state_d = (num_segs == '0) ? S_DONE : S_FETCH;
        end
`endif
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        seg_d   = seg_in;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = S_SETTLE;
      end
      // The ISSUE cycle plus SETTLE_CYCLES-1 settle cycles hide the drawer's stale write_done.
      S_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (write_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (index_q == last_idx) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef LINE_SEQ_ERASE_EN
        if (start && erase) begin
          pend_d     = 1'b1;
          pend_num_d = num_segs;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge draw_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
`ifdef LINE_SEQ_ERASE_EN
      color_q    <= 1'b1;
      pend_q     <= 1'b0;
      pend_num_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
`ifdef LINE_SEQ_ERASE_EN
      color_q    <= color_d;
      pend_q     <= pend_d;
      pend_num_q <= pend_num_d;
`endif
    end
  end

  assign seg_addr = index_q[ADDR_W-1:0];
  assign x0       = seg_q.x0;
  assign y0       = seg_q.y0;
  assign x1       = seg_q.x1;
  assign y1       = seg_q.y1;

  // Pulses are masked while reset is asserted so an aborted frame emits nothing.
  assign nextstate = (state_q == S_ISSUE) && !reset;
  assign done      = (state_q == S_DONE) && !reset;
  assign cleared   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy      = !cleared;
`ifdef LINE_SEQ_ERASE_EN
  assign color     = color_q;
`else
  assign color     = 1'b1;
`endif

endmodule
